// File: rtl/store_buffer_ctrl.sv
// Store buffer and single-owner data bus controller: queues stores in a FIFO,
// drains them in the background and lets loads bypass unless a queued store hits the same word.
module store_buffer_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [3:0]    st_sel,
   input  logic [31:0]   st_wdata,
   output logic          st_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_done,
   output logic [31:0]   ld_rdata,
   output logic          data_req,
   output logic          data_wr,
   output logic [3:0]    data_wstrb,
   output logic [AW-1:0] data_addr,
   output logic [31:0]   data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [31:0]   data_rdata,
   output logic          sb_empty
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST_ADDR, ST_DATA} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;

   logic [AW-1:0]   addr_mem [DEPTH];
   logic [3:0]      sel_mem  [DEPTH];
   logic [31:0]     data_mem [DEPTH];

   logic            push, pop, hit;

   // NOTE: the entry storage carries no reset; validity comes only from count/pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= st_addr;
         sel_mem[wr_ptr_q]  <= st_sel;
         data_mem[wr_ptr_q] <= st_wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q &&
             addr_mem[i][AW-1:2] == ld_addr[AW-1:2])
            hit = 1'b1;
      end
   end

   assign st_ready = (count_q < (PW+1)'(DEPTH));
   assign push     = st_valid & st_ready & (|st_sel);
   assign ld_rdata = data_rdata;
   assign sb_empty = (count_q == '0) && (state_q == IDLE);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      ld_done    = 1'b0;
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_wstrb = 4'b0000;
      data_addr  = '0;
      data_wdata = '0;
      unique case (state_q)
         IDLE: begin
            if (ld_valid && !hit)
               state_d = LD_ADDR;
            else if (count_q != '0)
               state_d = ST_ADDR;
         end
         LD_ADDR: begin
            data_req  = 1'b1;
            data_addr = ld_addr & ~AW'(3);
            if (data_addr_ok)
               state_d = LD_DATA;
         end
         LD_DATA: begin
            if (data_data_ok) begin
               ld_done = 1'b1;
               state_d = IDLE;
            end
         end
         ST_ADDR: begin
            data_req   = 1'b1;
            data_wr    = 1'b1;
            data_addr  = addr_mem[rd_ptr_q];
            data_wstrb = sel_mem[rd_ptr_q];
            data_wdata = data_mem[rd_ptr_q];
            if (data_addr_ok)
               state_d = ST_DATA;
         end
         ST_DATA: begin
            if (data_data_ok) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: a transaction-level queue model is compared every
// cycle, and a bus log plus literal expectations pin ordering, latency and reset behaviour.
module tb_store_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [3:0]  st_sel;
   logic [31:0] st_wdata;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_done;
   logic [31:0] ld_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        sb_empty;

   store_buffer_ctrl #(.DEPTH(4), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_sel(st_sel), .st_wdata(st_wdata),
      .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_done(ld_done), .ld_rdata(ld_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a queue of pending stores plus the one bus transaction in flight.
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } st_t;
   st_t mq[$];
   int  txn = 0;   // 0 none, 1 load, 2 store
   bit  acc = 0;   // address phase of the in-flight transaction accepted

   always @(posedge clk) begin
      int  pre;
      bit  push_now, mhit;
      if (rst) begin
         mq.delete();
         txn = 0;
         acc = 0;
      end else begin
         pre      = mq.size();
         push_now = st_valid && pre < 4 && st_sel != 4'b0000;
         if (txn != 0 && acc) begin
            if (data_data_ok) begin
               if (txn == 2) void'(mq.pop_front());
               txn = 0;
            end
         end else if (txn != 0) begin
            if (data_addr_ok) acc = 1;
         end else begin
            mhit = 0;
            foreach (mq[i]) if ((mq[i].addr >> 2) == (ld_addr >> 2)) mhit = 1;
            if (ld_valid && !mhit) txn = 1;
            else if (pre > 0)      txn = 2;
            acc = 0;
         end
         if (push_now) mq.push_back('{st_addr, st_sel, st_wdata});
      end
   end

   always @(negedge clk) begin
      bit exp_req, exp_done;
      if (chk_on) begin
         exp_req  = (txn != 0) && !acc;
         exp_done = (txn == 1) && acc && data_data_ok && !rst;
         check("st_ready", st_ready, mq.size() < 4);
         check("sb_empty", sb_empty, mq.size() == 0 && txn == 0);
         check("data_req", data_req, exp_req);
         check("ld_done",  ld_done,  exp_done);
         if (exp_req && txn == 1) begin
            check("ld_wr",   data_wr,    0);
            check("ld_addr", data_addr,  ld_addr & ~32'h3);
            check("ld_strb", data_wstrb, 0);
         end
         if (exp_req && txn == 2) begin
            check("st_wr",    data_wr,    1);
            check("st_addr",  data_addr,  mq[0].addr);
            check("st_strb",  data_wstrb, mq[0].sel);
            check("st_wdata", data_wdata, mq[0].data);
         end
         if (exp_done) check("ld_rdata", ld_rdata, data_rdata);
      end
   end

   // Bus log of accepted address phases and completion timestamps.
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  strb;
   } bus_t;
   bus_t blog[$];
   int   cyc = 0;
   int   wr_done_cyc = 0;
   int   ld_done_cyc = 0;
   bit   wr_pend = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         wr_pend = 0;
      end else begin
         if (wr_pend && data_data_ok) begin
            wr_done_cyc = cyc;
            wr_pend     = 0;
         end
         if (data_req && data_addr_ok) begin
            blog.push_back('{data_wr, data_addr, data_wstrb});
            if (data_wr) wr_pend = 1;
         end
         if (ld_done) ld_done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bit ok = 0;
      st_valid = 1; st_addr = a; st_sel = s; st_wdata = d;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (st_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      tick();
      st_valid = 0;
      check("push_accept", ok, 1);
   endtask

   task automatic do_load(input logic [31:0] a, output int lat);
      bit ok = 0;
      lat = -1;
      ld_valid = 1; ld_addr = a;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ld_done === 1'b1) begin
            ok = 1;
            lat = k;
            break;
         end
         tick();
      end
      tick();
      ld_valid = 0;
      check("load_done", ok, 1);
   endtask

   task automatic wait_empty(input string nm);
      bit ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (sb_empty === 1'b1) begin
            ok = 1;
            break;
         end
      end
      tick();
      check(nm, ok, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      rst = 1; st_valid = 1; st_addr = 32'h100; st_sel = 4'hF; st_wdata = 32'h1;
      ld_valid = 1; ld_addr = 32'h300; data_addr_ok = 1; data_data_ok = 1;
      data_rdata = 32'hCAFE_F00D;

      // 1: reset with requests active
      tick(); tick();
      @(negedge clk);
      check("rst_req",   data_req,   0);
      check("rst_wr",    data_wr,    0);
      check("rst_strb",  data_wstrb, 0);
      check("rst_addr",  data_addr,  0);
      check("rst_wdata", data_wdata, 0);
      check("rst_done",  ld_done,    0);
      check("rst_ready", st_ready,   1);
      check("rst_empty", sb_empty,   1);
      st_valid = 0; ld_valid = 0;
      tick();
      chk_on = 1;
      rst = 0;
      tick();

      // load latency on an empty FIFO with a zero-wait bus
      do_load(32'h0000_0044, lat);
      check("ld_latency", lat, 2);

      // 2: fill the FIFO with the bus stalled, then drain in order
      data_addr_ok = 0; data_data_ok = 0;
      blog.delete();
      for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
      st_valid = 1; st_addr = 32'h110; st_sel = 4'hF; st_wdata = 32'hA4;
      @(negedge clk);
      check("full_ready", st_ready, 0);
      tick(); tick(); tick();
      check("stall_req_held", data_req, 1);
      data_addr_ok = 1; data_data_ok = 1;
      push(32'h110, 4'hF, 32'hA4);
      wait_empty("drain2");
      check("t2_count", blog.size(), 5);
      foreach (blog[i]) begin
         check("t2_wr",   blog[i].wr,   1);
         check("t2_addr", blog[i].addr, 32'h100 + 32'(4 * i));
      end

      // 3: a non-matching load bypasses a queued store
      blog.delete();
      data_rdata = 32'h1234_5678;
      push(32'h200, 4'hF, 32'hB0);
      do_load(32'h300, lat);
      wait_empty("drain3");
      check("t3_count", blog.size(), 2);
      if (blog.size() == 2) begin
         check("t3_first_rd", blog[0].wr,   0);
         check("t3_rd_addr",  blog[0].addr, 32'h300);
         check("t3_then_wr",  blog[1].wr,   1);
         check("t3_wr_addr",  blog[1].addr, 32'h200);
      end

      // 4: a matching byte store must write before the load reads
      blog.delete();
      data_rdata = 32'h5A00_0000;
      push(32'h203, 4'b1000, 32'h5A5A_5A5A);
      do_load(32'h200, lat);
      wait_empty("drain4");
      check("t4_count", blog.size(), 2);
      if (blog.size() == 2) begin
         check("t4_wr_first", blog[0].wr,   1);
         check("t4_wr_addr",  blog[0].addr, 32'h203);
         check("t4_wr_strb",  blog[0].strb, 4'b1000);
         check("t4_rd_after", blog[1].wr,   0);
         check("t4_rd_addr",  blog[1].addr, 32'h200);
      end
      check("t4_gap_ge2", (ld_done_cyc - wr_done_cyc) >= 2, 1);

      // 5a: zero strobe is accepted but never queued
      blog.delete();
      push(32'h400, 4'b0000, 32'hDEAD);
      @(negedge clk);
      check("sel0_empty", sb_empty, 1);
      tick(); tick(); tick();
      check("sel0_no_bus", blog.size(), 0);

      // 5b: full FIFO while the head pops: st_ready stays low that cycle
      data_addr_ok = 0; data_data_ok = 0;
      for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 4'hF, 32'hC0 + 32'(i));
      tick();
      data_addr_ok = 1;
      tick();
      data_addr_ok = 0; data_data_ok = 1;
      st_valid = 1; st_addr = 32'h600; st_sel = 4'hF; st_wdata = 32'hC4;
      @(negedge clk);
      check("full_pop_ready", st_ready, 0);
      tick();
      data_data_ok = 0;
      @(negedge clk);
      check("after_pop_ready", st_ready, 1);
      tick();
      st_valid = 0;
      data_addr_ok = 1; data_data_ok = 1;
      wait_empty("drain5");
      check("t5_count", blog.size(), 5);
      if (blog.size() == 5) check("t5_last", blog[4].addr, 32'h600);

      // 6: reset during the data phase drops the store and the late data_ok
      blog.delete();
      data_addr_ok = 1; data_data_ok = 0;
      push(32'h700, 4'hF, 32'hE0);
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0; data_data_ok = 1;
      @(negedge clk);
      check("rst6_empty", sb_empty, 1);
      check("rst6_done",  ld_done,  0);
      tick(); tick(); tick();
      check("rst6_one_addr", blog.size(), 1);
      check("rst6_still_empty", sb_empty, 1);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
